dfp_burst_adapter: RTL and testbench

//   Memory-side responder for the cache dfp port: accepts 256-bit cacheline read/write

---
 rtl/dfp_burst_adapter.sv | 134 +++++++++++++
 tb/tb_dfp_burst_adapter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dfp_burst_adapter.sv
// rtl/dfp_burst_adapter.sv - cacheline dfp port to 4-beat burst memory adapter
module dfp_burst_adapter #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64,
  parameter int BEATS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_wdata,
  output logic [LINE_BITS-1:0] dfp_rdata,
  output logic                 dfp_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  localparam int              KW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0]   LAST_BEAT  = KW'(BEATS - 1);
  localparam logic [31:0]     ALIGN_MASK = ~32'(LINE_BITS / 8 - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_BURST,
    RESP
  } state_t;

  state_t               state, state_next;
  logic [KW-1:0]        beat, beat_next;
  logic                 rd_hit;
  logic [LINE_BITS-1:0] line_q;

  // State and beat counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Next-state and beat-advance logic; bmem_addr doubles as the latched line address
  always_comb begin
    state_next = state;
    beat_next  = beat;
    rd_hit     = 1'b0;
    case (state)
      IDLE: begin
        beat_next = '0;
        if (dfp_write)     state_next = WR_BURST;
        else if (dfp_read) state_next = RD_REQ;
      end
      RD_REQ: begin
        if (bmem_ready) state_next = RD_DATA;
      end
      RD_DATA: begin
        if (bmem_rvalid && (bmem_raddr == bmem_addr)) begin
          rd_hit = 1'b1;
          if (beat == LAST_BEAT) begin
            beat_next  = '0;
            state_next = RESP;
          end else begin
            beat_next = beat + 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          if (beat == LAST_BEAT) begin
            beat_next  = '0;
            state_next = RESP;
          end else begin
            beat_next = beat + 1'b1;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered outputs and line buffer; strobes follow the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dfp_rdata  <= '0;
      dfp_resp   <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
      line_q     <= '0;
    end else begin
      dfp_resp   <= (state_next == RESP);
      bmem_read  <= (state_next == RD_REQ);
      bmem_write <= (state_next == WR_BURST);

      if (state == IDLE && (dfp_write || dfp_read))
        bmem_addr <= dfp_addr & ALIGN_MASK;

      // Beat 0 comes straight from the request; later beats from the latched line
      if (state == IDLE && dfp_write) begin
        line_q     <= dfp_wdata;
        bmem_wdata <= dfp_wdata[BEAT_BITS-1:0];
      end else if (state == WR_BURST && state_next == WR_BURST) begin
        bmem_wdata <= line_q[int'(beat_next)*BEAT_BITS +: BEAT_BITS];
      end else begin
        bmem_wdata <= '0;
      end

      // The final beat bypasses line_q so dfp_rdata is complete on the resp cycle
      if (rd_hit) begin
        line_q[int'(beat)*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
        if (beat == LAST_BEAT)
          dfp_rdata <= {bmem_rdata, line_q[LINE_BITS-BEAT_BITS-1:0]};
      end
    end
  end

endmodule

// File: tb/tb_dfp_burst_adapter.sv
// tb/tb_dfp_burst_adapter.sv - scoreboard bench for dfp_burst_adapter
module tb_dfp_burst_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  dfp_addr = '0;
  logic         dfp_read = 1'b0;
  logic         dfp_write = 1'b0;
  logic [255:0] dfp_wdata = '0;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready = 1'b1;
  logic [31:0]  bmem_raddr = '0;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_rvalid = 1'b0;

  dfp_burst_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int resp_cnt = 0;

  logic [255:0] exp_rdata[$];
  logic [31:0]  exp_raddr[$];
  logic [31:0]  exp_waddr[$];
  logic [63:0]  exp_wdata[$];
  logic [255:0] last_rline = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: pops scoreboard entries as the DUT issues commands, beats and responses
  always @(negedge clk) begin
    if (rst) begin
      if (bmem_read)  rd_cnt++;
      if (bmem_write) wr_cnt++;
      if (bmem_read && bmem_ready) begin
        if (exp_raddr.size() == 0) check("unexpected_bmem_read", 1, 0);
        else check("bmem_read_addr", bmem_addr, exp_raddr.pop_front());
      end
      if (bmem_write && bmem_ready) begin
        if (exp_wdata.size() == 0) check("unexpected_bmem_write", 1, 0);
        else begin
          check("bmem_write_addr", bmem_addr, exp_waddr.pop_front());
          check("bmem_wdata", bmem_wdata, exp_wdata.pop_front());
        end
      end
      if (dfp_resp) begin
        resp_cnt++;
        if (exp_rdata.size() == 0) check("unexpected_dfp_resp", 1, 0);
        else check("dfp_rdata", dfp_rdata, exp_rdata.pop_front());
      end
    end
  end

  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] line, input int low_len, input bit stray);
    logic [31:0] al;
    logic [31:0] aq[$];
    logic [63:0] bq[$];
    int exp_resp, got_resp, first_cmd, b0, lo_start, rd0, wr0;
    al = addr & 32'hFFFF_FFE0;
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        exp_wdata.push_back(line[64*i +: 64]);
        exp_waddr.push_back(al);
      end
      exp_rdata.push_back(last_rline);
    end else begin
      exp_raddr.push_back(al);
      exp_rdata.push_back(line);
      last_rline = line;
    end
    for (int i = 0; i < 4; i++) begin
      if (stray && i == 2) begin
        aq.push_back(32'h0);
        bq.push_back(64'hBAD0_BAD0_BAD0_BAD0);
      end
      aq.push_back(al);
      bq.push_back(line[64*i +: 64]);
    end
    lo_start = wr ? 2 : 1;
    b0 = 2 + low_len;
    exp_resp = wr ? 5 + low_len : b0 + aq.size();
    got_resp = -1;
    first_cmd = -1;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    dfp_addr = addr; dfp_read = rd; dfp_write = wr; dfp_wdata = line;
    for (int n = 1; n <= 40 && got_resp < 0; n++) begin
      @(posedge clk); #1;
      bmem_ready = !(n >= lo_start && n < lo_start + low_len);
      if (n == 2) begin
        dfp_addr = ~addr;
        dfp_wdata = ~line;
      end
      if (!wr && n >= b0 && (n - b0) < aq.size()) begin
        bmem_rvalid = 1'b1;
        bmem_raddr = aq[n-b0];
        bmem_rdata = bq[n-b0];
      end else begin
        bmem_rvalid = 1'b0;
      end
      @(negedge clk);
      if (first_cmd < 0 && (bmem_read || bmem_write)) first_cmd = n;
      if (dfp_resp) got_resp = n;
    end
    check("first_cmd_cycle", first_cmd, 1);
    check("resp_cycle", got_resp, exp_resp);
    if (wr) begin
      check("wr_strobe_cycles", wr_cnt - wr0, 4 + low_len);
      check("no_bmem_read", rd_cnt - rd0, 0);
    end else begin
      check("rd_strobe_cycles", rd_cnt - rd0, 1 + low_len);
    end
    @(posedge clk); #1;
    dfp_read = 1'b0; dfp_write = 1'b0; bmem_rvalid = 1'b0; bmem_ready = 1'b1;
    @(negedge clk);
    check("resp_one_cycle", dfp_resp, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_dfp_resp"}, dfp_resp, 0);
    check({tag, "_dfp_rdata"}, dfp_rdata, 0);
    check({tag, "_bmem_read"}, bmem_read, 0);
    check({tag, "_bmem_write"}, bmem_write, 0);
    check({tag, "_bmem_addr"}, bmem_addr, 0);
    check({tag, "_bmem_wdata"}, bmem_wdata, 0);
  endtask

  task automatic reset_mid_read();
    logic [31:0] al;
    int r0, c0;
    al = 32'h3000_0080;
    exp_raddr.push_back(al);
    @(posedge clk); #1;
    dfp_addr = al; dfp_read = 1'b1; bmem_ready = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      if (n >= 2) begin
        bmem_rvalid = 1'b1;
        bmem_raddr = al;
        bmem_rdata = 64'hE0E0_0000_0000_0000 | 64'(n);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bmem_rdata = 64'hE0E0_0000_0000_0004;
    #1;
    check_cleared("mid_rst");
    dfp_read = 1'b0;
    last_rline = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    bmem_rdata = 64'hE0E0_0000_0000_0005;
    r0 = resp_cnt;
    c0 = rd_cnt;
    @(posedge clk); #1;
    bmem_rvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_no_resp", resp_cnt, r0);
    check("rst_no_read", rd_cnt, c0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    run_txn(0, 1, 32'h1000_0040,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0);
    run_txn(1, 0, 32'h2000_0060,
            {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 0, 0);
    run_txn(1, 0, 32'h2000_0080,
            {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
             64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A}, 3, 0);
    run_txn(0, 1, 32'h1000_0100,
            {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'h5555_AAAA_5555_AAAA, 64'hA5A5_5A5A_A5A5_5A5A}, 2, 0);
    run_txn(0, 1, 32'h1000_005F,
            {64'h9999_0000_9999_0004, 64'h9999_0000_9999_0003,
             64'h9999_0000_9999_0002, 64'h9999_0000_9999_0001}, 0, 1);
    run_txn(1, 1, 32'h4000_0020,
            {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
             64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001}, 0, 0);
    reset_mid_read();
    run_txn(0, 1, 32'h3000_0080,
            {64'h8888_1111_0000_0004, 64'h8888_1111_0000_0003,
             64'h8888_1111_0000_0002, 64'h8888_1111_0000_0001}, 0, 0);
    repeat (2) @(negedge clk);
    check("pending_rd_resp", exp_rdata.size(), 0);
    check("pending_rd_cmd", exp_raddr.size(), 0);
    check("pending_wr_beats", exp_wdata.size(), 0);
    check("total_resp", resp_cnt, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
